// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between N bus masters and the rr_arbiter.
// master drives request and sees the grant; slave is the arbiter side.
interface rr_arbiter_if #(
  parameter int N = 4
) ();
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   request;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_valid;

  modport master (
    output request,
    input  grant,
    input  grant_id,
    input  grant_valid
  );

  modport slave (
    input  request,
    output grant,
    output grant_id,
    output grant_valid
  );
endinterface

// File: rtl/rr_arbiter.sv
// N-way arbiter: registered one-hot grant, round-robin or fixed priority,
// pre-empts an owner after MAX_HOLD cycles when others wait.
// Ports: clk, rst (async active-low), bus (request in; grant/id/valid out).
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int RR_MODE  = 1
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter_if.slave  bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] MAXH = 8'(MAX_HOLD);

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] id_q, id_d;
  logic           valid_q;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     hcnt_q, hcnt_d;

  logic [N-1:0]   cand;
  logic           own_req;
  logic           hi_hit, lo_hit, win_hit;
  logic [IDW-1:0] hi_idx, lo_idx, win_idx;
  logic           take;

  // The owner is always excluded from the candidates; in IDLE grant_q
  // is zero, so this is plain request there.
  assign cand    = bus.request & ~grant_q;
  assign own_req = |(bus.request & grant_q);

  // lo: lowest set bit overall. hi: lowest set bit at or above ptr.
  // Round-robin prefers hi and falls back to lo, giving the wrap.
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_hit = 1'b0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lo_hit = 1'b1;
        lo_idx = IDW'(i);
        if (i >= int'(ptr_q)) begin
          hi_hit = 1'b1;
          hi_idx = IDW'(i);
        end
      end
    end
    win_hit = lo_hit;
    win_idx = (RR_MODE != 0 && hi_hit) ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        take = win_hit;
      end
      GRANTED: begin
        if (!own_req) begin
          if (win_hit) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
            hcnt_d  = '0;
          end
        end else if (hcnt_q < MAXH) begin
          hcnt_d = hcnt_q + 8'd1;
        end else begin
          take = win_hit;
        end
      end
    endcase
    if (take) begin
      state_d = GRANTED;
      grant_d = N'(1) << win_idx;
      id_d    = win_idx;
      ptr_d   = (win_idx == IDW'(N - 1)) ? '0 : win_idx + 1'b1;
      hcnt_d  = 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      valid_q <= |grant_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = id_q;
  assign bus.grant_valid = valid_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed test of rr_arbiter: reset, rotation, hand-off, pre-empt,
// and fixed-priority mode on a second instance.
module tb_rr_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  rr_arbiter_if #(.N(4)) ifa ();
  rr_arbiter_if #(.N(4)) ifb ();

  rr_arbiter #(
    .N(4), .MAX_HOLD(4), .RR_MODE(1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  rr_arbiter #(
    .N(4), .MAX_HOLD(2), .RR_MODE(0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ifa.request = 4'b1111;
    ifb.request = 4'b0000;

    #7 rst = 1'b0;
    #1;
    chk("rst_g",  32'(ifa.grant), 32'h0);
    chk("rst_id", 32'(ifa.grant_id), 32'h0);
    chk("rst_v",  32'(ifa.grant_valid), 32'h0);
    #3;
    chk("rst_g2", 32'(ifa.grant), 32'h0);
    chk("rst_v2", 32'(ifa.grant_valid), 32'h0);
    #1 rst = 1'b1;

    for (int k = 0; k < 17; k++) begin
      tick();
      chk("rot_g",  32'(ifa.grant), 32'(1 << ((k / 4) % 4)));
      chk("rot_id", 32'(ifa.grant_id), 32'((k / 4) % 4));
      chk("rot_v",  32'(ifa.grant_valid), 32'h1);
    end

    #2 rst = 1'b0;
    #1;
    chk("mid_rst_g", 32'(ifa.grant), 32'h0);
    chk("mid_rst_v", 32'(ifa.grant_valid), 32'h0);
    ifa.request = 4'b0000;
    #2 rst = 1'b1;
    tick();
    chk("idle_g", 32'(ifa.grant), 32'h0);

    ifa.request = 4'b0001;
    tick();
    chk("single_g",  32'(ifa.grant), 32'h1);
    chk("single_id", 32'(ifa.grant_id), 32'h0);
    chk("single_v",  32'(ifa.grant_valid), 32'h1);
    tick();
    tick();
    chk("single_g2", 32'(ifa.grant), 32'h1);

    ifa.request = 4'b0111;
    tick();
    chk("ho_keep", 32'(ifa.grant), 32'h1);
    ifa.request = 4'b0110;
    tick();
    chk("ho_g",  32'(ifa.grant), 32'h2);
    chk("ho_id", 32'(ifa.grant_id), 32'h1);
    ifa.request = 4'b0000;
    tick();
    chk("rel_g",  32'(ifa.grant), 32'h0);
    chk("rel_id", 32'(ifa.grant_id), 32'h0);
    chk("rel_v",  32'(ifa.grant_valid), 32'h0);

    ifa.request = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hog_g", 32'(ifa.grant), 32'h4);
    end
    ifa.request = 4'b0101;
    tick();
    chk("pre_g",  32'(ifa.grant), 32'h1);
    chk("pre_id", 32'(ifa.grant_id), 32'h0);
    ifa.request = 4'b0000;

    ifb.request = 4'b1010;
    begin
      logic [3:0] fx [6];
      fx = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0010, 4'b0010};
      for (int k = 0; k < 6; k++) begin
        tick();
        chk("fix_g", 32'(ifb.grant), 32'(fx[k]));
      end
    end
    ifb.request = 4'b1011;
    tick();
    chk("fix_b0",  32'(ifb.grant), 32'h1);
    chk("fix_id0", 32'(ifb.grant_id), 32'h0);
    chk("fix_v",   32'(ifb.grant_valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised N-requester arbiter with registered one-hot grant, round-robin or fixed-priority selection and a bounded hold time. It replaces the fixed 2-requester arbiter behind the `arbif` interface. It adds three things that arbiter lacks:
- a configurable requester count;
- fairness rotation;
- pre-emption of an owner that holds the grant too long.

It sits between N bus masters and one shared resource.

## Interface
- `N`, 4, number of requesters (≥2).
- `MAX_HOLD`, 4, maximum consecutive grant cycles (1..255) before forced rotation when others are waiting.
- `RR_MODE`, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
- `IDW`, max(1,$clog2(N)), derived width of `grant_id` (localparam).
- `clk`  in  1  clock, all state on posedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `request`  in  N  per-requester request level, sampled on posedge clk.
- `grant`  out  N  registered grant, one-hot or all-zero.
- `grant_id`  out  IDW  index of current owner; 0 when no grant.
- `grant_valid`  out  1  equals |grant.

## Operation
- Reset (`rst` low, asynchronous) clears the following immediately, with no clock needed:
  - `grant`=0, `grant_id`=0, `grant_valid`=0;
  - priority pointer `ptr`=0, hold counter `hcnt`=0, state IDLE.
- Winner search in round-robin mode: first set bit of the candidate mask, scanning from `ptr` upward with wrap at N-1→0.
- Winner search in fixed mode: lowest set index; `ptr` is ignored.
- On every new grant to index w: `ptr` ← (w+1) mod N and `hcnt` ← 1.
- State IDLE:
  - `request`≠0 → grant the winner over `request`; go to GRANTED.
  - Otherwise outputs stay zero.
- State GRANTED, owner k:
  - `request[k]`=0 (release): re-arbitrate over `request` with bit k masked. A winner, if any, is granted at this same edge, with no idle bubble. If there is none, `grant`←0 and go to IDLE.
  - `request[k]`=1 and `hcnt`<MAX_HOLD: keep the grant; `hcnt`++.
  - `request[k]`=1, `hcnt`=MAX_HOLD, another request pending: pre-empt. Grant the winner over `request` with bit k masked.
  - `request[k]`=1, `hcnt`=MAX_HOLD, no other request: keep the grant; `hcnt` saturates at MAX_HOLD.
- Non-owner requests that change mid-grant are ignored until the next arbitration point.
- A requester may be re-granted only after an arbitration cycle in which it was not masked.
- `grant` is never multi-hot. `grant_id` and `grant_valid` are registered together with `grant`, so all three are consistent every cycle.
- Counter width is 8 bits. MAX_HOLD=1 means rotation on every cycle while any other requester is waiting.

## Timing
- Latency:
  - request→grant: 1 edge (request sampled at edge e, `grant` visible after edge e).
  - release→next grant: 1 edge.
  - release→`grant`=0: 1 edge.
- With continuous contention from N requesters, each owner holds for exactly MAX_HOLD cycles.
- Worst-case wait for a held request: (N-1)·MAX_HOLD cycles in round-robin mode. It is unbounded in fixed mode for higher indices.
- `rst` assertion at any point, including mid-grant, drops `grant` asynchronously.
- On deassertion, the first arbitration happens at the first posedge with `rst` high.

## Test plan
- Reset: drive `rst` low at 7 ns for 5 ns with `request`=4'b1111.
  - Required: `grant`=0, `grant_id`=0, `grant_valid`=0 throughout.
  - Re-assert `rst` mid-grant: `grant` goes to 0 before the next clk edge.
- Single request, N=4: `request`=4'b0001 driven at edge e.
  - Required: `grant`=4'b0001, `grant_id`=0, `grant_valid`=1 after edge e.
  - Required: grant still 4'b0001 two edges later.
- Rotation, N=4, MAX_HOLD=4: `request`=4'b1111 held.
  - Required: `grant` sequence 0001×4, 0010×4, 0100×4, 1000×4, then 0001 again.
- Release hand-off: owner 0 with `request`=4'b0111 drops to 4'b0110.
  - Required: `grant`=4'b0010 on the next edge, with no zero cycle.
  - Then `request`=0: `grant`=0 one edge later, state IDLE.
- Hog and pre-empt: `request`=4'b0100 alone for 10 cycles.
  - Required: `grant`=4'b0100 for all 10 cycles.
  - Then `request`=4'b0101: `grant`=4'b0001 one edge later (`hcnt` already saturated, `ptr`=3 wraps to 0).
- Fixed mode, RR_MODE=0, MAX_HOLD=2: `request`=4'b1010 held.
  - Required: `grant` alternates 0010×2, 1000×2, 0010×2.
  - Adding bit 0 at an arbitration point: `grant`=4'b0001 next.
